io_uart_tx: RTL

// - Memory-mapped UART transmitter; responder on the core's 8-bit-address IO bus (MMU is the initiator).
// - CPU stores bytes into a TX FIFO.
// - An internal FSM serialises each byte as 8N1 on pin tx, LSB first.
// - Provides status and an optional transmit-complete interrupt.

---
 rtl/io_uart_tx.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/io_uart_tx.sv
// io_uart_tx: memory-mapped 8N1 UART transmitter on the 8-bit-address IO bus.
// The CPU pushes bytes into a small TX FIFO. A four-state FSM serialises each
// byte LSB first on tx. Status, baud divider and interrupt enable are readable.
// Optional feature macro: IO_UART_TX_PARITY_EN.
// When it is defined, CTRL[1] enables a parity bit and CTRL[2] selects odd parity.
module io_uart_tx #(
  parameter logic [7:0]  BASE_ADDR   = 8'h40,
  parameter int          FIFO_DEPTH  = 4,
  parameter logic [15:0] DEFAULT_DIV = 16'd15
) (
  input  logic        clk,
  input  logic        resetb,
  input  logic [7:0]  io_addr,
  input  logic        io_en,
  input  logic        io_we,
  input  logic [31:0] io_data_write,
  output logic [31:0] io_data_read,
  output logic        tx,
  output logic        irq
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

`ifdef IO_UART_TX_PARITY_EN
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} state_t;
`endif

  // Bus decode
  logic w_sel, w_wr;
  logic w_wrTxData, w_wrStatus, w_wrBaud, w_wrCtrl;

  // FIFO
  logic [7:0]    r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wrPtr, r_rdPtr;
  logic [CW-1:0] r_count;
  logic          w_full, w_empty, w_push, w_pop, w_ovfSet;
  logic [7:0]    w_popData;

  // Control and status registers
  logic [15:0] r_baudDiv;
  logic        r_irqEn;
  logic        r_ovf;
`ifdef IO_UART_TX_PARITY_EN
  logic        r_parEn, r_parOdd;
  logic        r_frameParEn, r_parBit;
  logic        w_frameParEnNext, w_parBitNext;
`endif

  // Serialiser
  state_t      r_state, w_stateNext;
  logic [15:0] r_timer, w_timerNext;
  logic [15:0] r_period, w_periodNext;
  logic [2:0]  r_bitCnt, w_bitCntNext;
  logic [7:0]  r_shift, w_shiftNext;
  logic        r_tx, w_txNext;
  logic        w_bitDone, w_busy;
  logic [31:0] w_ctrlRead;
  logic        w_unused;

  assign w_sel      = io_en & (io_addr[7:4] == BASE_ADDR[7:4]);
  assign w_wr       = w_sel & io_we;
  assign w_wrTxData = w_wr & (io_addr[3:2] == 2'd0);
  assign w_wrStatus = w_wr & (io_addr[3:2] == 2'd1);
  assign w_wrBaud   = w_wr & (io_addr[3:2] == 2'd2);
  assign w_wrCtrl   = w_wr & (io_addr[3:2] == 2'd3);

  // Upper write-data bits and the byte-lane address bits carry no meaning here.
  assign w_unused = ^{io_data_write[31:16], io_addr[1:0]};

  assign w_full    = (r_count == CW'(FIFO_DEPTH));
  assign w_empty   = (r_count == '0);
  assign w_pop     = (r_state == S_IDLE) & ~w_empty;
  // A pop in the same cycle frees a slot, so a push into a full FIFO still fits.
  assign w_push    = w_wrTxData & (~w_full | w_pop);
  assign w_ovfSet  = w_wrTxData & w_full & ~w_pop;
  assign w_popData = r_mem[r_rdPtr];

  assign w_busy    = (r_state != S_IDLE);
  assign w_bitDone = (r_timer == r_period);

  assign tx  = r_tx;
  assign irq = r_irqEn & w_empty & ~w_busy;

  // FIFO storage; contents need no reset because the pointers gate validity.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wrPtr] <= io_data_write[7:0];
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wrPtr <= r_wrPtr + AW'(1);
      if (w_pop)  r_rdPtr <= r_rdPtr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (!w_push && w_pop) r_count <= r_count - CW'(1);
    end
  end

  // Software-visible registers; overflow setting wins over a same-cycle clear.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_baudDiv <= DEFAULT_DIV;
      r_irqEn   <= 1'b0;
      r_ovf     <= 1'b0;
`ifdef IO_UART_TX_PARITY_EN
      r_parEn   <= 1'b0;
      r_parOdd  <= 1'b0;
`endif
    end else begin
      if (w_wrBaud) r_baudDiv <= io_data_write[15:0];
      if (w_wrCtrl) begin
        r_irqEn  <= io_data_write[0];
`ifdef IO_UART_TX_PARITY_EN
        r_parEn  <= io_data_write[1];
        r_parOdd <= io_data_write[2];
`endif
      end
      if (w_ovfSet)                          r_ovf <= 1'b1;
      else if (w_wrStatus && io_data_write[3]) r_ovf <= 1'b0;
    end
  end

  // Serialiser state register; tx is registered so the pin never glitches.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_state  <= S_IDLE;
      r_timer  <= '0;
      r_period <= '0;
      r_bitCnt <= '0;
      r_shift  <= '0;
      r_tx     <= 1'b1;
`ifdef IO_UART_TX_PARITY_EN
      r_frameParEn <= 1'b0;
      r_parBit     <= 1'b0;
`endif
    end else begin
      r_state  <= w_stateNext;
      r_timer  <= w_timerNext;
      r_period <= w_periodNext;
      r_bitCnt <= w_bitCntNext;
      r_shift  <= w_shiftNext;
      r_tx     <= w_txNext;
`ifdef IO_UART_TX_PARITY_EN
      r_frameParEn <= w_frameParEnNext;
      r_parBit     <= w_parBitNext;
`endif
    end
  end

  // Next-state logic: frame sequencing, bit timing and the next tx level.
  always_comb begin
    w_stateNext  = r_state;
    w_timerNext  = w_bitDone ? 16'd0 : r_timer + 16'd1;
    w_periodNext = r_period;
    w_bitCntNext = r_bitCnt;
    w_shiftNext  = r_shift;
    w_txNext     = 1'b1;
`ifdef IO_UART_TX_PARITY_EN
    w_frameParEnNext = r_frameParEn;
    w_parBitNext     = r_parBit;
`endif
    case (r_state)
      S_IDLE: begin
        w_timerNext = 16'd0;
        if (!w_empty) begin
          w_stateNext  = S_START;
          w_shiftNext  = w_popData;
          w_periodNext = r_baudDiv;
`ifdef IO_UART_TX_PARITY_EN
          w_frameParEnNext = r_parEn;
          w_parBitNext     = (^w_popData) ^ r_parOdd;
`endif
        end
      end
      S_START: begin
        if (w_bitDone) begin
          w_stateNext  = S_DATA;
          w_bitCntNext = 3'd0;
        end
      end
      S_DATA: begin
        if (w_bitDone) begin
          w_shiftNext  = {1'b0, r_shift[7:1]};
          w_bitCntNext = r_bitCnt + 3'd1;
          if (r_bitCnt == 3'd7) begin
`ifdef IO_UART_TX_PARITY_EN
            w_stateNext = r_frameParEn ? S_PARITY : S_STOP;
`else
            w_stateNext = S_STOP;
`endif
          end
        end
      end
`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: begin
        if (w_bitDone) w_stateNext = S_STOP;
      end
`endif
      S_STOP: begin
        if (w_bitDone) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase

    case (w_stateNext)
      S_START: w_txNext = 1'b0;
      S_DATA:  w_txNext = w_shiftNext[0];
`ifdef IO_UART_TX_PARITY_EN
      S_PARITY: w_txNext = w_parBitNext;
`endif
      default: w_txNext = 1'b1;
    endcase
  end

`ifdef IO_UART_TX_PARITY_EN
  assign w_ctrlRead = {29'd0, r_parOdd, r_parEn, r_irqEn};
`else
  assign w_ctrlRead = {31'd0, r_irqEn};
`endif

  // Combinational read mux; an unselected or write access reads as zero.
  always_comb begin
    io_data_read = 32'd0;
    if (w_sel && !io_we) begin
      case (io_addr[3:2])
        2'd1:    io_data_read = {28'd0, r_ovf, w_busy, w_empty, w_full};
        2'd2:    io_data_read = {16'd0, r_baudDiv};
        2'd3:    io_data_read = w_ctrlRead;
        default: io_data_read = 32'd0;
      endcase
    end
  end

endmodule
